// File: rtl/hardmax_pkg.sv
// Shared helpers for the pipelined hardmax comparator tree.
// Covers tree sizing and the float "greater than" rule used at every node.
package hardmax_pkg;

  function automatic int unsigned hm_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned hm_levels(input int unsigned n);
    return hm_clog2(n);
  endfunction

  function automatic int unsigned hm_idx_width(input int unsigned n);
    return (hm_clog2(n) == 0) ? 1 : hm_clog2(n);
  endfunction

  // Number of entries held at tree level k for n channels.
  function automatic int unsigned hm_count(input int unsigned n, input int unsigned k);
    return (n + (32'd1 << k) - 1) >> k;
  endfunction

  // Operands are zero-extended words of 'width' bits; the sign is bit width-1.
  function automatic logic fp_greater(input logic [63:0] a, input logic [63:0] b,
                                      input logic signed_mode, input int unsigned width);
    logic [63:0] mask;
    logic [63:0] ma;
    logic [63:0] mb;
    logic        sa;
    logic        sb;
    if (!signed_mode) return a > b;
    mask = (64'd1 << (width - 1)) - 64'd1;
    sa   = |((a >> (width - 1)) & 64'd1);
    sb   = |((b >> (width - 1)) & 64'd1);
    ma   = a & mask;
    mb   = b & mask;
    if (ma == '0 && mb == '0) return 1'b0;  // +0 and -0 compare equal
    if (sa != sb) return sb;
    if (!sa) return ma > mb;
    return ma < mb;
  endfunction

endpackage

// File: rtl/hardmax_cmp_node.sv
// One tree node: picks the larger-C entry of a pair and registers it.
// Entry layout is {present, v, w, c, idx}; ties and absent right keep the left entry.
module hardmax_cmp_node
  import hardmax_pkg::*;
#(
  parameter  int FPW         = 32,
  parameter  int IDXW        = 3,
  parameter  int SIGNED_MODE = 0,
  localparam int EW          = 1 + 3 * FPW + IDXW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic [EW-1:0] l_i,
  input  logic [EW-1:0] r_i,
  output logic [EW-1:0] y_o
);

  logic [FPW-1:0] c_l;
  logic [FPW-1:0] c_r;
  logic           r_wins;
  logic [EW-1:0]  y_d;
  logic [EW-1:0]  y_q;

  assign c_l = l_i[IDXW +: FPW];
  assign c_r = r_i[IDXW +: FPW];

  always_comb begin
    r_wins = r_i[EW-1] & (~l_i[EW-1] | fp_greater(64'(c_r), 64'(c_l), SIGNED_MODE != 0, FPW));
    y_d    = r_wins ? r_i : l_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)     y_q <= '0;
    else if (en_i) y_q <= y_d;
  end

  assign y_o = y_q;

endmodule

// File: rtl/hardmax_tree.sv
// Pipelined hardmax: registered inputs, then one registered comparator level per tree stage.
// ready_i stalls every stage at once; outputs come straight from the last stage register.
module hardmax_tree
  import hardmax_pkg::*;
#(
  parameter  int EXP_WIDTH    = 8,
  parameter  int FRAC_WIDTH   = 23,
  parameter  int NO_COMPARORS = 8,
  parameter  int SIGNED_MODE  = 0,
  localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH,
  localparam int LEVELS       = hm_levels(NO_COMPARORS),
  localparam int IDX_WIDTH    = hm_idx_width(NO_COMPARORS)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [FP_WIDTH_REG*NO_COMPARORS-1:0] v_i,
  input  logic [FP_WIDTH_REG*NO_COMPARORS-1:0] w_i,
  input  logic [FP_WIDTH_REG*NO_COMPARORS-1:0] c_i,
  input  logic                                 valid_i,
  input  logic                                 ready_i,
  output logic                                 ready_o,
  output logic [FP_WIDTH_REG-1:0]              v_o,
  output logic [FP_WIDTH_REG-1:0]              w_o,
  output logic [FP_WIDTH_REG-1:0]              c_o,
  output logic [IDX_WIDTH-1:0]                 idx_o,
  output logic                                 valid_o
);

  localparam int FPW = FP_WIDTH_REG;
  localparam int EW  = 1 + 3 * FPW + IDX_WIDTH;

  logic [EW-1:0] stg [0:LEVELS][0:NO_COMPARORS-1];
  logic [LEVELS:0] valid_d;
  logic [LEVELS:0] valid_q;

  assign ready_o = ready_i;

  for (genvar j = 0; j < NO_COMPARORS; j++) begin : g_in
    logic [EW-1:0] in_d;
    logic [EW-1:0] in_q;
    assign in_d = {1'b1, v_i[j*FPW +: FPW], w_i[j*FPW +: FPW], c_i[j*FPW +: FPW], IDX_WIDTH'(j)};
    always_ff @(posedge clk_i) begin
      if (rst_i)        in_q <= '0;
      else if (ready_i) in_q <= in_d;
    end
    assign stg[0][j] = in_q;
  end

  // Odd-count levels register their last entry alone rather than pairing it.
  for (genvar lv = 1; lv <= LEVELS; lv++) begin : g_lvl
    localparam int PREV = hm_count(NO_COMPARORS, lv - 1);
    for (genvar j = 0; j < NO_COMPARORS; j++) begin : g_node
      if (j < PREV / 2) begin : g_cmp
        hardmax_cmp_node #(
          .FPW        (FPW),
          .IDXW       (IDX_WIDTH),
          .SIGNED_MODE(SIGNED_MODE)
        ) u_node (
          .clk_i(clk_i),
          .rst_i(rst_i),
          .en_i (ready_i),
          .l_i  (stg[lv-1][2*j]),
          .r_i  (stg[lv-1][2*j+1]),
          .y_o  (stg[lv][j])
        );
      end else if (j == PREV / 2 && (PREV % 2) == 1) begin : g_pass
        logic [EW-1:0] pass_q;
        always_ff @(posedge clk_i) begin
          if (rst_i)        pass_q <= '0;
          else if (ready_i) pass_q <= stg[lv-1][2*j];
        end
        assign stg[lv][j] = pass_q;
      end else begin : g_none
        assign stg[lv][j] = '0;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (ready_i) begin
      valid_d[0] = valid_i;
      for (int unsigned i = 1; i <= LEVELS; i++) valid_d[i] = valid_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  assign v_o     = stg[LEVELS][0][EW-2 -: FPW];
  assign w_o     = stg[LEVELS][0][EW-2-FPW -: FPW];
  assign c_o     = stg[LEVELS][0][IDX_WIDTH +: FPW];
  assign idx_o   = stg[LEVELS][0][IDX_WIDTH-1:0];
  assign valid_o = valid_q[LEVELS];

endmodule

// File: doc/hardmax_tree.md
Name: hardmax_tree

Overview:
- Pipelined comparator-tree successor to the naive channel hardmax in the dfdd datapath.
- Takes NO_COMPARORS (V, W, C) float triples plus a valid, selects the channel with the greatest C, and returns its V, W, C and channel index.
- Register per tree level for timing at large channel counts.
- Adds optional signed-float compare, deterministic tie-break, non-power-of-two channel counts and a global stall.

Parameters:
- EXP_WIDTH, 8, exponent bits of the float format.
- FRAC_WIDTH, 23, fraction bits of the float format.
- NO_COMPARORS, 8, channel count; must be >= 1, any value allowed.
- SIGNED_MODE, 0, 0 = unsigned compare of the full word (positive-only inputs); 1 = sign-magnitude float compare.
- FP_WIDTH_REG, 1+EXP_WIDTH+FRAC_WIDTH, local: word width.
- LEVELS, $clog2(NO_COMPARORS), local: tree depth.
- IDX_WIDTH, max(1, $clog2(NO_COMPARORS)), local: index width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- v_i  in  FP_WIDTH_REG x NO_COMPARORS  per-channel V.
- w_i  in  FP_WIDTH_REG x NO_COMPARORS  per-channel W.
- c_i  in  FP_WIDTH_REG x NO_COMPARORS  per-channel compare key C.
- valid_i  in  1  input beat valid.
- ready_i  in  1  downstream ready; 0 stalls the whole pipeline.
- ready_o  out  1  equals ready_i (combinational pass-through).
- v_o  out  FP_WIDTH_REG  V of the winning channel.
- w_o  out  FP_WIDTH_REG  W of the winning channel.
- c_o  out  FP_WIDTH_REG  C of the winning channel.
- idx_o  out  IDX_WIDTH  winning channel index.
- valid_o  out  1  output beat valid.

Behaviour:
- Stage 0 is the input register. Stages 1..LEVELS each hold one tree level of ceil(N/2^k) nodes. Outputs come straight from the last stage register, with no combinational logic on outputs.
- Latency: 1 + LEVELS cycles from valid_i & ready_i to valid_o. For N=1 the latency is 1 and idx_o = 0.
- Stall: all stages, including valid bits, advance only when ready_i = 1. With ready_i = 0 every register holds, including valid_o and the data outputs. Inputs presented while ready_i = 0 are not captured; the upstream must hold them.
- Valid is a per-stage bit travelling with the data. Bubbles propagate as valid = 0, and the data in a bubble is don't-care but deterministic.
- Each node carries a present bit. Odd-count levels pass the last entry straight through with a register; they never pair it with a phantom entry. An absent entry never wins.
- Node rule: right wins only if C_right > C_left under the active compare. A tie keeps left, so the lowest channel index wins. The node forwards the winner's V, W, C and index.
- SIGNED_MODE = 0: plain unsigned compare of the full FP_WIDTH_REG word.
- SIGNED_MODE = 1 compare rules:
  - If signs differ, the positive value is greater, except that +0 and -0 compare equal.
  - If both are positive, the larger magnitude is greater.
  - If both are negative, the smaller magnitude is greater.
  - NaN and Inf are not supported; their result is don't-care.
- Reset: while rst_i = 1 at a clock edge, all valid bits, data, index and present registers clear to 0. This holds regardless of ready_i. After reset, v_o = w_o = c_o = 0, idx_o = 0 and valid_o = 0.
- Reset mid-operation flushes all in-flight beats; none are emitted afterwards.
- Throughput is one beat per cycle while ready_i = 1.

Decomposition:
- Package hardmax_pkg holds:
  - function fp_greater(a, b, signed_mode, width), implementing the compare rules above;
  - the localparam helpers for LEVELS and IDX_WIDTH.
- One sub-module, hardmax_cmp_node: a two-input comparator plus pipeline register, with enable and synchronous reset, carrying {present, v, w, c, idx}. The top instantiates the node tree in a generate loop per level and handles pass-through for odd counts.

Test Plan:
- N=8, SIGNED_MODE=0, ready_i=1, C = {1.0, 5.0, 3.0, 5.0, 2.0, 0.5, 4.0, 1.5}. Required: 4 cycles later valid_o = 1, c_o = 5.0, idx_o = 1 (tie goes to the lower index), v_o/w_o = channel 1 values.
- N=5 (odd). Max in channel 4 (C=9.0), others at 1.0. Required: idx_o = 4 and c_o = 9.0 after 4 cycles. Also with all-equal C = 2.0, idx_o = 0.
- N=4, SIGNED_MODE=1, C = {-3.0, -1.0, -0.0, -7.0}. Required: idx_o = 2. With C = {-0.0, +0.0, -1.0, -2.0}, idx_o = 0 (±0 tie).
- Back-to-back beats on 6 consecutive cycles with distinct maxima, then ready_i = 0 for 3 cycles mid-stream. Required: outputs and valid_o frozen during the stall, all 6 results emitted in order, none lost or duplicated.
- Assert rst_i for 1 cycle while 3 beats are in flight. Required: the next cycle shows valid_o = 0 and all outputs = 0, and no stale beats appear afterwards. Also assert rst_i while ready_i = 0 and require the same clear.
- N=1. Required: latency 1, idx_o = 0, and outputs equal the registered inputs.
